// File: rtl/elixirchip_es1_spu_pkg.sv
// elixirchip_es1_spu_pkg: shared types and the counter step function for the SPU op blocks.
// Provides count_t (widest supported count), COUNT_MAX_BITS, and next_count().
// next_count() is the single definition of increment / wrap / saturate used by the counter.
package elixirchip_es1_spu_pkg;

  localparam int unsigned COUNT_MAX_BITS = 32;

  typedef logic [COUNT_MAX_BITS-1:0] count_t;

  // One counter step. The caller passes its width as an all-ones mask, so narrow
  // counters can share this function with the widest one.
  function automatic count_t next_count(input count_t count, input logic inc,
                                        input logic sat, input count_t mask);
    count_t nxt;
    nxt = count;
    if (inc) begin
      if (sat && (count == mask)) begin
        nxt = count;
      end else begin
        nxt = (count + count_t'(1)) & mask;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// elixirchip_es1_spu_delay: valid-gated delay line; a stage only takes new data when the
// stage feeding it holds a valid result, so the output holds across invalid slots.
// Ports: clk, reset (sync, active-high), cke (freeze), in_data/in_valid, out_data.
module elixirchip_es1_spu_delay #(
  parameter int unsigned STAGES = 0,
  parameter int unsigned WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cke,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_wire
    assign out_data = in_data;
    // Nothing is registered here, so the timing/control inputs go unread.
    wire unused_ok = &{1'b0, clk, reset, cke, in_valid};
  end else if (STAGES == 1) begin : g_one
    logic [WIDTH-1:0] dat;
    always_ff @(posedge clk) begin
      if (reset) begin
        dat <= '0;
      end else if (cke && in_valid) begin
        dat <= in_data;
      end
    end
    assign out_data = dat;
  end else begin : g_many
    logic [WIDTH-1:0]  dat [STAGES];
    // vld[k] marks dat[k] as holding a fresh result; the last stage's valid
    // is never needed because nothing sits downstream of it.
    logic [STAGES-2:0] vld;
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < int'(STAGES); k++) begin
          dat[k] <= '0;
        end
        vld <= '0;
      end else if (cke) begin
        if (in_valid) begin
          dat[0] <= in_data;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
          if (vld[k-1]) begin
            dat[k] <= dat[k-1];
          end
        end
        vld[0] <= in_valid;
        for (int k = 1; k < int'(STAGES) - 1; k++) begin
          vld[k] <= vld[k-1];
        end
      end
    end
    assign out_data = dat[STAGES-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_count.sv
// elixirchip_es1_spu_op_count: counts cycles with s_valid && s_data, s_clear reloads CLEAR_VALUE;
// result reaches m_data LATENCY cke-edges after sampling and holds between valid/clear results.
// Ports: clk, reset (sync, active-high), cke, s_data, s_clear, s_valid -> m_data[COUNT_BITS].
// Build option: define ELIXIRCHIP_ES1_SPU_OP_COUNT_SATURATE_EN to saturate at all-ones instead of wrapping.
module elixirchip_es1_spu_op_count #(
  parameter int unsigned           LATENCY     = 1,
  parameter int unsigned           COUNT_BITS  = 8,
  parameter logic [COUNT_BITS-1:0] CLEAR_VALUE = '0,
  parameter string                 DEVICE      = "RTL",
  parameter string                 SIMULATION  = "false",
  parameter string                 DEBUG       = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic                  s_data,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [COUNT_BITS-1:0] m_data
);

  import elixirchip_es1_spu_pkg::*;

  if (LATENCY < 1) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_count: LATENCY must be >= 1");
  end
  if (COUNT_BITS < 1 || COUNT_BITS > COUNT_MAX_BITS) begin : g_bad_width
    $error("elixirchip_es1_spu_op_count: COUNT_BITS out of range");
  end
  if (DEVICE == "") begin : g_bad_device
    $error("elixirchip_es1_spu_op_count: DEVICE must be named");
  end
  if ((SIMULATION != "true" && SIMULATION != "false") ||
      (DEBUG != "true" && DEBUG != "false")) begin : g_bad_switch
    $error("elixirchip_es1_spu_op_count: switches take \"true\" or \"false\"");
  end

`ifdef ELIXIRCHIP_ES1_SPU_OP_COUNT_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  localparam int unsigned STAGES     = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam count_t      COUNT_MASK = {COUNT_MAX_BITS{1'b1}} >> (COUNT_MAX_BITS - COUNT_BITS);

  // Stage 0: the counter itself is the first pipeline register.
  logic [COUNT_BITS-1:0] count;
  logic                  stage0_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      stage0_valid <= 1'b0;
    end else if (cke) begin
      // Clear wins over a coincident event; the event is dropped.
      if (s_clear) begin
        count <= CLEAR_VALUE;
      end else begin
        count <= COUNT_BITS'(next_count(count_t'(count), s_valid & s_data, SAT, COUNT_MASK));
      end
      // A valid sample with no event still re-emits the unchanged count.
      stage0_valid <= s_valid | s_clear;
    end
  end

  elixirchip_es1_spu_delay #(
    .STAGES (STAGES),
    .WIDTH  (COUNT_BITS)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .in_data  (count),
    .in_valid (stage0_valid),
    .out_data (m_data)
  );

endmodule

// File: tb/tb_elixirchip_es1_spu_op_count.sv
module tb_elixirchip_es1_spu_op_count;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned CB_A  = 8;
  localparam int unsigned CLR_A = 0;
  localparam int unsigned LAT_B = 4;
  localparam int unsigned CB_B  = 4;
  localparam int unsigned CLR_B = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cke = 1'b0;
  logic s_data = 1'b0;
  logic s_clear = 1'b0;
  logic s_valid = 1'b0;
  logic [CB_A-1:0] m_data_a;
  logic [CB_B-1:0] m_data_b;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_count #(
    .LATENCY(LAT_A), .COUNT_BITS(CB_A), .CLEAR_VALUE(CB_A'(CLR_A)),
    .DEVICE("RTL"), .SIMULATION("true"), .DEBUG("false")
  ) u_dut_a (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m_data_a)
  );

  elixirchip_es1_spu_op_count #(
    .LATENCY(LAT_B), .COUNT_BITS(CB_B), .CLEAR_VALUE(CB_B'(CLR_B)),
    .DEVICE("RTL"), .SIMULATION("true"), .DEBUG("false")
  ) u_dut_b (
    .clk(clk), .reset(reset), .cke(cke), .s_data(s_data),
    .s_clear(s_clear), .s_valid(s_valid), .m_data(m_data_b)
  );

  typedef struct {
    bit          vld;
    int unsigned val;
  } res_t;

  res_t        q_a[$];
  res_t        q_b[$];
  int unsigned cnt_a = 0, cnt_b = 0;
  int unsigned exp_a = 0, exp_b = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: m_data=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned bump(input int unsigned c, input int unsigned bits);
    int unsigned top;
    top = (32'd1 << bits) - 1;
`ifdef ELIXIRCHIP_ES1_SPU_OP_COUNT_SATURATE_EN
    if (c == top) return c;
`endif
    return (c + 1) & top;
  endfunction

  // One clock: drive, let the edge happen, advance the model, then compare.
  task automatic cyc(input string tag, input logic r, input logic c,
                     input logic v, input logic d, input logic cl);
    res_t it;
    reset = r; cke = c; s_valid = v; s_data = d; s_clear = cl;
    @(posedge clk);
    if (r) begin
      cnt_a = 0; cnt_b = 0; exp_a = 0; exp_b = 0;
      q_a.delete(); q_b.delete();
    end else if (c) begin
      if (cl) begin
        cnt_a = CLR_A; cnt_b = CLR_B;
      end else if (v && d) begin
        cnt_a = bump(cnt_a, CB_A); cnt_b = bump(cnt_b, CB_B);
      end
      q_a.push_back('{vld: (v || cl), val: cnt_a});
      q_b.push_back('{vld: (v || cl), val: cnt_b});
      if (q_a.size() == LAT_A) begin
        it = q_a.pop_front();
        if (it.vld) exp_a = it.val;
      end
      if (q_b.size() == LAT_B) begin
        it = q_b.pop_front();
        if (it.vld) exp_b = it.val;
      end
    end
    #1;
    chk({tag, "/lat1"}, int'(m_data_a), exp_a);
    chk({tag, "/lat4"}, int'(m_data_b), exp_b);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic events(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset, including one reset cycle with cke low.
    cyc("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("reset_nocke", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle("reset_idle", 2);

    // 1: five events -> 1..5
    events("count5", 5);
    idle("count5_flush", 5);

    // 2: alternating event flag, then idle hold
    cyc("clr2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc("alt", 1'b0, 1'b1, 1'b1, (i % 2) == 0, 1'b0);
    idle("alt_hold", 6);

    // 3: clear with a coincident event, then one more event
    events("pre_clr", 3);
    cyc("clr_evt", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    events("post_clr", 1);
    idle("post_clr_idle", 5);

    // 4: wrap / saturate on the 4-bit counter
    cyc("clr4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    events("wrap", 17);
    idle("wrap_idle", 5);

    // 5: cke low with events held
    cyc("clr5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    events("pre_freeze", 2);
    for (int i = 0; i < 3; i++) cyc("freeze", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    events("resume", 3);
    cyc("freeze_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("resume_idle", 5);

    // 6: reset with the pipeline full of in-flight counts
    cyc("clr6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("clr6_idle", 4);
    cyc("rst6_pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    events("fill", 7);
    cyc("rst6", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle("no_stale", 6);

    // Randomized mix of all inputs.
    for (int i = 0; i < 200; i++) begin
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
          $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 11) == 0));
    end
    idle("rand_flush", 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
